// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Parity support is compiled in by defining UART_TX_PARITY_EN.
module uart_tx #(
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       baud_x16_ce,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_e     state_q;
    logic [7:0] shift_q;
    logic [3:0] os_cnt_q;
    logic [3:0] os_cnt_d;
    logic [2:0] bit_cnt_q;
    logic       stop_cnt_q;
    logic       tx_o_q;
    logic       tx_busy_q;
    logic       tx_done_q;
    logic       bit_end;

`ifdef UART_TX_PARITY_EN
    // The shift register is consumed while sending, so parity is captured at accept.
    logic parity_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    assign bit_end = baud_x16_ce && (os_cnt_q == 4'd15);

    always_comb begin
        os_cnt_d = os_cnt_q;
        if (state_q != IDLE && baud_x16_ce) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            os_cnt_q   <= 4'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_o_q     <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            os_cnt_q  <= os_cnt_d;
            case (state_q)
                IDLE: begin
                    tx_o_q    <= 1'b1;
                    tx_busy_q <= 1'b0;
                    if (tx_en) begin
                        shift_q    <= tx_data;
                        os_cnt_q   <= 4'd0;
                        bit_cnt_q  <= 3'd0;
                        stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= (^tx_data) ^ PARITY_ODD;
`endif
                        tx_o_q     <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_o_q  <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_o_q  <= parity_q;
                            state_q <= PARITY;
`else
                            tx_o_q  <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_o_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_o_q  <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            tx_busy_q <= 1'b0;
                            tx_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_o    = tx_o_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) driven in lockstep and compared
// each clock against a frame-level model built from bit index = ce pulses / 16.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk_50 = 1'b0;
    logic       reset = 1'b1;
    logic       baud_x16_ce = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en = 1'b0;
    logic       d1_busy, d1_done, d1_tx;
    logic       d2_busy, d2_done, d2_tx;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = 1 stop bit / even parity, 1 = 2 stop bits / odd parity
    logic       m_busy [2];
    logic       m_done [2];
    logic       m_line [2];
    logic [7:0] m_byte [2];
    int         m_cnt  [2];

    always #5 clk_50 = ~clk_50;

    uart_tx #(.STOP_BITS(1), .PARITY_ODD(1'b0)) dut1 (
        .clk_50(clk_50), .reset(reset), .baud_x16_ce(baud_x16_ce), .tx_data(tx_data),
        .tx_en(tx_en), .tx_busy(d1_busy), .tx_done(d1_done), .tx_o(d1_tx)
    );

    uart_tx #(.STOP_BITS(2), .PARITY_ODD(1'b1)) dut2 (
        .clk_50(clk_50), .reset(reset), .baud_x16_ce(baud_x16_ce), .tx_data(tx_data),
        .tx_en(tx_en), .tx_busy(d2_busy), .tx_done(d2_done), .tx_o(d2_tx)
    );

    function automatic int frame_len(input int d);
        return 9 + PBITS + (d == 0 ? 1 : 2);
    endfunction

    // Line level of bit k of a frame: start, data LSB first, optional parity, stop bits.
    function automatic logic frame_bit(input logic [7:0] b, input bit odd, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return (^b) ^ odd;
`endif
        return 1'b1;
    endfunction

    task automatic model_step(input int d);
        m_done[d] = 1'b0;
        if (reset) begin
            m_busy[d] = 1'b0;
            m_line[d] = 1'b1;
        end else if (!m_busy[d]) begin
            m_line[d] = 1'b1;
            if (tx_en) begin
                m_byte[d] = tx_data;
                m_busy[d] = 1'b1;
                m_cnt[d]  = 0;
                m_line[d] = 1'b0;
            end
        end else if (baud_x16_ce) begin
            m_cnt[d]++;
            if (m_cnt[d] == frame_len(d) * 16) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b1;
                m_line[d] = 1'b1;
            end else begin
                m_line[d] = frame_bit(m_byte[d], d == 1, m_cnt[d] / 16);
            end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge sample them, then compare all outputs 1 ns later.
    task automatic cycle(input logic rst, input logic en, input logic ce, input logic [7:0] data);
        reset       = rst;
        tx_en       = en;
        baud_x16_ce = ce;
        tx_data     = data;
        @(posedge clk_50);
        model_step(0);
        model_step(1);
        #1;
        check("d1.tx_o", d1_tx, m_line[0]);
        check("d1.tx_busy", d1_busy, m_busy[0]);
        check("d1.tx_done", d1_done, m_done[0]);
        check("d2.tx_o", d2_tx, m_line[1]);
        check("d2.tx_busy", d2_busy, m_busy[1]);
        check("d2.tx_done", d2_done, m_done[1]);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        int done_cnt;
        logic [7:0] b;

        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b0; m_line[d] = 1'b1;
            m_byte[d] = 8'h00; m_cnt[d] = 0;
        end

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        $display("reset: tx_o=%b busy=%b done=%b", d1_tx, d1_busy, d1_done);

        // 0x55 with ce tied high and a single-clock request
        busy_cnt = 0; done_at = -1;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, i == 0, 1'b1, 8'h55);
            if (d1_busy) busy_cnt++;
            if (d1_done) done_at = i;
            if (i % 16 == 8 && i / 16 <= 8) check("d1.0x55_seq", d1_tx, logic'((i / 16) % 2));
        end
        check_int("d1.0x55_busy_clocks", busy_cnt, 16 * (10 + PBITS));
        check_int("d1.0x55_done_clock", done_at, 16 * (10 + PBITS));
        $display("frame 0x55 ce=1: busy=%0d done_at=%0d", busy_cnt, done_at);

        // 0xA3 with ce every 4th clock; instance 2 carries two stop bits
        busy_cnt = 0;
        for (int i = 0; i < 760; i++) begin
            cycle(1'b0, i == 0, (i % 4 == 0) && (i > 0), 8'hA3);
            if (d2_busy) busy_cnt++;
        end
        check_int("d2.0xA3_busy_clocks", busy_cnt, 64 * (11 + PBITS));
        $display("frame 0xA3 ce/4: busy=%0d", busy_cnt);

        // tx_en held high with tx_data changing every clock: back-to-back frames
        for (int i = 0; i < 400; i++) cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
        $display("held tx_en: back-to-back frames with changing tx_data");

        // Reset during data bit 3, then a fresh frame
        b = 8'($urandom);
        for (int i = 0; i < 16 + 3 * 16 + 5; i++) cycle(1'b0, i == 0, 1'b1, b);
        cycle(1'b1, 1'b0, 1'b1, b);
        check("d1.abort_tx_o", d1_tx, 1'b1);
        check("d1.abort_busy", d1_busy, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b1, b);
            if (d1_done || d2_done) done_cnt++;
        end
        check_int("abort_no_done", done_cnt, 0);
        b = 8'($urandom);
        for (int i = 0; i < 200; i++) cycle(1'b0, i == 0, 1'b1, b);
        $display("mid-frame reset then frame 0x%02h", b);

        // Request coinciding with reset must not start a frame
        cycle(1'b1, 1'b1, 1'b1, 8'h3C);
        check("d1.rst_en_busy", d1_busy, 1'b0);
        check("d2.rst_en_tx_o", d2_tx, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h3C);
        $display("reset with tx_en: no frame");

        // Random requests, data, baud enables and rare resets
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 999) == 0, $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), 8'($urandom));
        end
        for (int i = 0; i < 800; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        $display("random traffic done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
